// File: rtl/relu_activation.sv
// Multi-lane ReLU with optional upper clip; 1-cycle registered latency.
// No backpressure: one beat accepted per clock, outputs hold when in_valid is low.
module relu_activation #(
   parameter int DATA_W = 8,
   parameter int LANES  = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   input  logic [LANES*DATA_W-1:0]    relu_in,
   input  logic                       clip_en,
   input  logic [DATA_W-1:0]          clip_max,
   output logic                       out_valid,
   output logic [LANES*DATA_W-1:0]    relu_out,
   output logic [$clog2(LANES+1)-1:0] neg_count
);

   localparam int CW = $clog2(LANES + 1);

   logic [DATA_W-1:0]       cap;
   logic [LANES-1:0]        lane_neg;
   logic [LANES*DATA_W-1:0] res_next;
   logic [CW-1:0]           neg_sum;

   // A negative clip bound collapses the cap to zero.
   assign cap = clip_max[DATA_W-1] ? '0 : clip_max;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      logic [DATA_W-1:0] x;
      logic [DATA_W-1:0] pos;

      assign x           = relu_in[k*DATA_W +: DATA_W];
      assign lane_neg[k] = x[DATA_W-1];
      assign pos         = lane_neg[k] ? '0 : x;
      // pos and cap both have a clear MSB, so an unsigned compare is exact.
      assign res_next[k*DATA_W +: DATA_W] = (clip_en && (pos > cap)) ? cap : pos;
   end

   always_comb begin
      neg_sum = '0;
      for (int k = 0; k < LANES; k++) begin
         neg_sum = neg_sum + CW'(lane_neg[k]);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         relu_out  <= '0;
         neg_count <= '0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            relu_out  <= res_next;
            neg_count <= neg_sum;
         end
      end
   end

endmodule

// File: tb/tb_relu_activation.sv
// Randomized and directed checks of relu_activation against an integer reference model.
module tb_relu_activation;

   localparam int DATA_W = 8;
   localparam int LANES  = 4;
   localparam int CW     = $clog2(LANES + 1);

   logic                       clk;
   logic                       rst_n;
   logic                       in_valid;
   logic [LANES*DATA_W-1:0]    relu_in;
   logic                       clip_en;
   logic [DATA_W-1:0]          clip_max;
   logic                       out_valid;
   logic [LANES*DATA_W-1:0]    relu_out;
   logic [CW-1:0]              neg_count;

   int checks   = 0;
   int failures = 0;

   logic                    e_vld;
   logic [LANES*DATA_W-1:0] e_out;
   int                      e_cnt;

   relu_activation #(.DATA_W(DATA_W), .LANES(LANES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .relu_in   (relu_in),
      .clip_en   (clip_en),
      .clip_max  (clip_max),
      .out_valid (out_valid),
      .relu_out  (relu_out),
      .neg_count (neg_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [LANES*DATA_W-1:0] pack(input int a, input int b, input int c, input int d);
      logic [LANES*DATA_W-1:0] v;
      v[0*DATA_W +: DATA_W] = DATA_W'(a);
      v[1*DATA_W +: DATA_W] = DATA_W'(b);
      v[2*DATA_W +: DATA_W] = DATA_W'(c);
      v[3*DATA_W +: DATA_W] = DATA_W'(d);
      return v;
   endfunction

   // Reference: y = max(x,0), then min(y, max(clip_max,0)) when clipping is on.
   task automatic model_edge();
      int x, y, cap, cnt;
      logic [LANES*DATA_W-1:0] res;
      if (!rst_n) begin
         e_vld = 1'b0;
         e_out = '0;
         e_cnt = 0;
      end else begin
         e_vld = in_valid;
         if (in_valid) begin
            cnt = 0;
            res = '0;
            cap = $signed(clip_max);
            if (cap < 0) cap = 0;
            for (int k = 0; k < LANES; k++) begin
               x = $signed(relu_in[k*DATA_W +: DATA_W]);
               if (x < 0) cnt++;
               y = (x < 0) ? 0 : x;
               if (clip_en && y > cap) y = cap;
               res[k*DATA_W +: DATA_W] = DATA_W'(y);
            end
            e_out = res;
            e_cnt = cnt;
         end
      end
   endtask

   task automatic tick(input string tag);
      model_edge();
      @(posedge clk);
      #1;
      check({tag, "_vld"}, 64'(out_valid), 64'(e_vld));
      check({tag, "_out"}, 64'(relu_out), 64'(e_out));
      check({tag, "_cnt"}, 64'(neg_count), 64'(e_cnt));
   endtask

   task automatic beat(input logic v, input logic [LANES*DATA_W-1:0] d,
                       input logic ce, input int cm);
      in_valid = v;
      relu_in  = d;
      clip_en  = ce;
      clip_max = DATA_W'(cm);
   endtask

   initial begin
      rst_n = 1'b0;
      beat(1'b1, {LANES{8'h7f}}, 1'b0, 0);
      tick("rst0");
      tick("rst1");
      check("rst_out_lit", 64'(relu_out), 64'(0));
      rst_n = 1'b1;
      beat(1'b0, {LANES{8'h7f}}, 1'b0, 0);
      tick("rel0");
      tick("rel1");

      beat(1'b1, pack(0, 1, 2, 3), 1'b0, 0);     tick("seq0");
      beat(1'b1, pack(25, 1, 2, 3), 1'b0, 0);    tick("seq1");
      beat(1'b1, pack(100, 1, 2, 3), 1'b0, 0);   tick("seq2");
      beat(1'b1, pack(-85, 1, 2, 3), 1'b0, 0);   tick("seq3");
      check("seq3_lit", 64'(relu_out), 64'(pack(0, 1, 2, 3)));

      beat(1'b1, pack(-128, 127, -1, 1), 1'b0, 0);
      tick("ext");
      check("ext_lit", 64'(relu_out), 64'(pack(0, 127, 0, 1)));
      check("ext_cnt_lit", 64'(neg_count), 64'(2));

      beat(1'b1, pack(100, 6, 5, -3), 1'b1, 6);
      tick("clip6");
      check("clip6_lit", 64'(relu_out), 64'(pack(6, 6, 5, 0)));
      beat(1'b1, pack(100, 6, 5, -3), 1'b1, -4);
      tick("clipn");
      check("clipn_lit", 64'(relu_out), 64'(pack(0, 0, 0, 0)));
      check("clipn_cnt_lit", 64'(neg_count), 64'(1));

      beat(1'b1, pack(10, 20, 30, 40), 1'b0, 0);
      tick("gapv");
      beat(1'b0, pack(-1, -2, -3, -4), 1'b1, 0);
      for (int i = 0; i < 3; i++) tick("gap");
      check("gap_hold_lit", 64'(relu_out), 64'(pack(10, 20, 30, 40)));

      for (int i = 0; i < 8; i++) begin
         beat(1'b1, $urandom, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)) - 128);
         tick("strm");
      end
      rst_n = 1'b0;
      beat(1'b1, $urandom, 1'b0, 0);
      tick("mrst");
      rst_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         beat(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 255)) - 128);
         tick("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
